// File: rtl/layer_norm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : layer_norm_ctrl
// Desc     : Command sequencer for a layer-norm datapath: one-shot config,
//            per-row beat streaming of source/gamma-beta reads, writeback.
// Revision : 1.0 - initial release
// ============================================================================
module layer_norm_ctrl #(
    parameter int BUS_NUM         = 8,
    parameter int DATA_NUM_WIDTH  = 10,
    parameter int SCALA_POS_WIDTH = 5,
    parameter int ROW_NUM_WIDTH   = 8,
    parameter int ADDR_WIDTH      = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_vld,
    output logic                       cmd_rdy,
    input  logic [ROW_NUM_WIDTH-1:0]   cmd_row_num,
    input  logic [DATA_NUM_WIDTH-1:0]  cmd_data_num,
    input  logic [SCALA_POS_WIDTH-1:0] cmd_in_scale_pos,
    input  logic [SCALA_POS_WIDTH-1:0] cmd_out_scale_pos,
    input  logic [ADDR_WIDTH-1:0]      cmd_src_base,
    input  logic [ADDR_WIDTH-1:0]      cmd_dst_base,
    output logic [DATA_NUM_WIDTH-1:0]  ln_data_num,
    output logic                       ln_data_num_vld,
    output logic [SCALA_POS_WIDTH-1:0] ln_in_scale_pos,
    output logic                       ln_in_scale_pos_vld,
    output logic [SCALA_POS_WIDTH-1:0] ln_out_scale_pos,
    output logic                       ln_out_scale_pos_vld,
    output logic                       src_rd_en,
    output logic [ADDR_WIDTH-1:0]      src_rd_addr,
    output logic                       param_rd_en,
    output logic [ADDR_WIDTH-1:0]      param_rd_addr,
    output logic [BUS_NUM-1:0]         ln_in_vld,
    output logic [BUS_NUM-1:0]         ln_param_vld,
    input  logic [BUS_NUM-1:0]         ln_out_vld,
    input  logic                       ln_out_last,
    output logic                       dst_wr_en,
    output logic [ADDR_WIDTH-1:0]      dst_wr_addr,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_LAST = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ROW_NUM_WIDTH-1:0]   r_row_num;
    logic [ROW_NUM_WIDTH-1:0]   r_row;
    logic [DATA_NUM_WIDTH-1:0]  r_data_num;
    logic [DATA_NUM_WIDTH-1:0]  r_beats;
    logic [DATA_NUM_WIDTH-1:0]  r_beat;
    logic [DATA_NUM_WIDTH-1:0]  r_ob;
    logic [SCALA_POS_WIDTH-1:0] r_in_sp;
    logic [SCALA_POS_WIDTH-1:0] r_out_sp;
    logic [ADDR_WIDTH-1:0]      r_src_base;
    logic [ADDR_WIDTH-1:0]      r_dst_base;
    logic [ADDR_WIDTH-1:0]      r_row_off;
    logic [BUS_NUM-1:0]         r_last_mask;
    logic [BUS_NUM-1:0]         r_lane_vld;

    logic                       w_accept;
    logic                       w_cfg;
    logic                       w_stream;
    logic                       w_last_beat;
    logic                       w_last_row;
    logic                       w_row_end;
    logic                       w_wr;
    logic [DATA_NUM_WIDTH-1:0]  w_cmd_beats;
    logic [31:0]                w_cmd_rem;
    logic [BUS_NUM-1:0]         w_cmd_mask;
    logic [BUS_NUM-1:0]         w_beat_mask;

    assign w_accept    = (r_state == ST_IDLE) && cmd_vld;
    assign w_cfg       = (r_state == ST_CFG);
    assign w_stream    = (r_state == ST_STREAM);
    assign w_last_beat = (r_beat == r_beats - DATA_NUM_WIDTH'(1));
    assign w_last_row  = (r_row == r_row_num - ROW_NUM_WIDTH'(1));
    assign w_row_end   = (r_state == ST_WAIT_LAST) && ln_out_last;
    assign w_wr        = ((r_state == ST_STREAM) || (r_state == ST_WAIT_LAST)) && (|ln_out_vld);

    // Beat count and final-beat lane mask are fixed per command, so derive once at accept.
    assign w_cmd_beats = DATA_NUM_WIDTH'((32'(cmd_data_num) + 32'(BUS_NUM) - 32'd1) / 32'(BUS_NUM));
    assign w_cmd_rem   = 32'(cmd_data_num) % 32'(BUS_NUM);

    always_comb begin
        w_cmd_mask = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            w_cmd_mask[i] = (w_cmd_rem == 32'd0) || (w_cmd_rem > i[31:0]);
        end
    end

    assign w_beat_mask = w_last_beat ? r_last_mask : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ((cmd_row_num == '0) || (cmd_data_num == '0)) ? ST_DONE : ST_CFG;
                end
            end
            ST_CFG:       w_state_next = ST_STREAM;
            ST_STREAM:    if (w_last_beat) w_state_next = ST_WAIT_LAST;
            ST_WAIT_LAST: if (ln_out_last) w_state_next = w_last_row ? ST_DONE : ST_STREAM;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_num   <= '0;
            r_row       <= '0;
            r_data_num  <= '0;
            r_beats     <= '0;
            r_beat      <= '0;
            r_ob        <= '0;
            r_in_sp     <= '0;
            r_out_sp    <= '0;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_row_off   <= '0;
            r_last_mask <= '0;
            r_lane_vld  <= '0;
        end else begin
            r_lane_vld <= w_stream ? w_beat_mask : '0;
            if (w_accept) begin
                r_row_num   <= cmd_row_num;
                r_data_num  <= cmd_data_num;
                r_in_sp     <= cmd_in_scale_pos;
                r_out_sp    <= cmd_out_scale_pos;
                r_src_base  <= cmd_src_base;
                r_dst_base  <= cmd_dst_base;
                r_beats     <= w_cmd_beats;
                r_last_mask <= w_cmd_mask;
                r_row       <= '0;
                r_row_off   <= '0;
                r_beat      <= '0;
                r_ob        <= '0;
            end else begin
                if (w_stream) begin
                    r_beat <= w_last_beat ? '0 : r_beat + DATA_NUM_WIDTH'(1);
                end
                // A write in the row-ending cycle already used the old ob, so clearing wins.
                if (w_row_end && !w_last_row) begin
                    r_row     <= r_row + ROW_NUM_WIDTH'(1);
                    r_row_off <= r_row_off + ADDR_WIDTH'(r_beats);
                    r_ob      <= '0;
                end else if (w_wr) begin
                    r_ob <= r_ob + DATA_NUM_WIDTH'(1);
                end
            end
        end
    end

    assign cmd_rdy              = (r_state == ST_IDLE);
    assign busy                 = (r_state != ST_IDLE);
    assign done                 = (r_state == ST_DONE);
    assign ln_data_num_vld      = w_cfg;
    assign ln_in_scale_pos_vld  = w_cfg;
    assign ln_out_scale_pos_vld = w_cfg;
    assign ln_data_num          = w_cfg ? r_data_num : '0;
    assign ln_in_scale_pos      = w_cfg ? r_in_sp : '0;
    assign ln_out_scale_pos     = w_cfg ? r_out_sp : '0;
    assign src_rd_en            = w_stream;
    assign param_rd_en          = w_stream;
    assign src_rd_addr          = r_src_base + r_row_off + ADDR_WIDTH'(r_beat);
    assign param_rd_addr        = ADDR_WIDTH'(r_beat);
    assign ln_in_vld            = r_lane_vld;
    assign ln_param_vld         = r_lane_vld;
    assign dst_wr_en            = w_wr;
    assign dst_wr_addr          = r_dst_base + r_row_off + ADDR_WIDTH'(r_ob);

endmodule
`default_nettype wire

// File: tb/tb_layer_norm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_norm_ctrl
// Desc     : Directed, table-driven bench for layer_norm_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  cmd_row_num;
    logic [9:0]  cmd_data_num;
    logic [4:0]  cmd_in_scale_pos;
    logic [4:0]  cmd_out_scale_pos;
    logic [11:0] cmd_src_base;
    logic [11:0] cmd_dst_base;
    logic [9:0]  ln_data_num;
    logic        ln_data_num_vld;
    logic [4:0]  ln_in_scale_pos;
    logic        ln_in_scale_pos_vld;
    logic [4:0]  ln_out_scale_pos;
    logic        ln_out_scale_pos_vld;
    logic        src_rd_en;
    logic [11:0] src_rd_addr;
    logic        param_rd_en;
    logic [11:0] param_rd_addr;
    logic [7:0]  ln_in_vld;
    logic [7:0]  ln_param_vld;
    logic [7:0]  ln_out_vld;
    logic        ln_out_last;
    logic        dst_wr_en;
    logic [11:0] dst_wr_addr;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    layer_norm_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_vld              (cmd_vld),
        .cmd_rdy              (cmd_rdy),
        .cmd_row_num          (cmd_row_num),
        .cmd_data_num         (cmd_data_num),
        .cmd_in_scale_pos     (cmd_in_scale_pos),
        .cmd_out_scale_pos    (cmd_out_scale_pos),
        .cmd_src_base         (cmd_src_base),
        .cmd_dst_base         (cmd_dst_base),
        .ln_data_num          (ln_data_num),
        .ln_data_num_vld      (ln_data_num_vld),
        .ln_in_scale_pos      (ln_in_scale_pos),
        .ln_in_scale_pos_vld  (ln_in_scale_pos_vld),
        .ln_out_scale_pos     (ln_out_scale_pos),
        .ln_out_scale_pos_vld (ln_out_scale_pos_vld),
        .src_rd_en            (src_rd_en),
        .src_rd_addr          (src_rd_addr),
        .param_rd_en          (param_rd_en),
        .param_rd_addr        (param_rd_addr),
        .ln_in_vld            (ln_in_vld),
        .ln_param_vld         (ln_param_vld),
        .ln_out_vld           (ln_out_vld),
        .ln_out_last          (ln_out_last),
        .dst_wr_en            (dst_wr_en),
        .dst_wr_addr          (dst_wr_addr),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rows;
        logic [9:0]  dn;
        logic [4:0]  isp;
        logic [4:0]  osp;
        logic [11:0] src;
        logic [11:0] dst;
        int          beats;
        logic [7:0]  mask;
        bit          hold_vld;
        bit          inj_last;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cfg_vld"}, 32'({ln_data_num_vld, ln_in_scale_pos_vld, ln_out_scale_pos_vld}), 32'd0);
        chk({tag, "_cfg_val"}, 32'({ln_data_num, ln_in_scale_pos, ln_out_scale_pos}), 32'd0);
        chk({tag, "_rd_en"}, 32'({src_rd_en, param_rd_en}), 32'd0);
        chk({tag, "_rd_addr"}, 32'({src_rd_addr, param_rd_addr}), 32'd0);
        chk({tag, "_lane_vld"}, 32'({ln_in_vld, ln_param_vld}), 32'd0);
        chk({tag, "_wr"}, 32'({dst_wr_en, dst_wr_addr}), 32'd0);
    endtask

    // Runs one command end to end; rst_row >= 0 pulses reset at beat 0 of that row and returns.
    task automatic run_cmd(input vec_t v, input int rst_row);
        logic [11:0] ea;
        logic [7:0]  exp_lane;
        cmd_vld           = 1'b1;
        cmd_row_num       = v.rows;
        cmd_data_num      = v.dn;
        cmd_in_scale_pos  = v.isp;
        cmd_out_scale_pos = v.osp;
        cmd_src_base      = v.src;
        cmd_dst_base      = v.dst;
        #1;
        chk("accept_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("accept_busy", 32'(busy), 32'd0);
        @(negedge clk);
        if (!v.hold_vld) cmd_vld = 1'b0;
        if (v.rows == 8'd0 || v.dn == 10'd0) begin
            ln_out_vld  = 8'hFF;
            ln_out_last = 1'b1;
            #1;
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_cfg_vld", 32'({ln_data_num_vld, ln_in_scale_pos_vld, ln_out_scale_pos_vld}), 32'd0);
            chk("zero_rd_en", 32'({src_rd_en, param_rd_en}), 32'd0);
            chk("zero_wr_en", 32'(dst_wr_en), 32'd0);
            @(negedge clk);
            ln_out_vld  = 8'h00;
            ln_out_last = 1'b0;
            cmd_vld     = 1'b0;
            #1;
            chk("zero_idle_done", 32'(done), 32'd0);
            chk("zero_idle_rdy", 32'(cmd_rdy), 32'd1);
            chk("zero_idle_lane", 32'(ln_in_vld), 32'd0);
            return;
        end
        #1;
        chk("cfg_vld", 32'({ln_data_num_vld, ln_in_scale_pos_vld, ln_out_scale_pos_vld}), 32'h7);
        chk("cfg_data_num", 32'(ln_data_num), 32'(v.dn));
        chk("cfg_in_sp", 32'(ln_in_scale_pos), 32'(v.isp));
        chk("cfg_out_sp", 32'(ln_out_scale_pos), 32'(v.osp));
        chk("cfg_rd_en", 32'(src_rd_en), 32'd0);
        chk("cfg_cmd_rdy", 32'(cmd_rdy), 32'd0);
        for (int r = 0; r < int'(v.rows); r++) begin
            for (int b = 0; b < v.beats; b++) begin
                @(negedge clk);
                ln_out_vld  = 8'h00;
                ln_out_last = (v.inj_last && r == 0 && b == 0);
                #1;
                ea       = v.src + 12'(r * v.beats + b);
                exp_lane = (b == 0) ? 8'h00 : 8'hFF;
                chk($sformatf("src_rd_en r%0d b%0d", r, b), 32'(src_rd_en), 32'd1);
                chk($sformatf("src_rd_addr r%0d b%0d", r, b), 32'(src_rd_addr), 32'(ea));
                chk($sformatf("param_rd r%0d b%0d", r, b), 32'({param_rd_en, param_rd_addr}), 32'({1'b1, 12'(b)}));
                chk($sformatf("ln_in_vld r%0d b%0d", r, b), 32'(ln_in_vld), 32'(exp_lane));
                chk($sformatf("ln_param_vld r%0d b%0d", r, b), 32'(ln_param_vld), 32'(exp_lane));
                chk($sformatf("stream_cmd_rdy r%0d b%0d", r, b), 32'(cmd_rdy), 32'd0);
                if (r == rst_row && b == 0) begin
                    rst        = 1'b1;
                    ln_out_vld = 8'hFF;
                    #1;
                    chk_rst("midrst");
                    @(negedge clk);
                    chk_rst("midrst_hold");
                    ln_out_vld  = 8'h00;
                    ln_out_last = 1'b0;
                    cmd_vld     = 1'b0;
                    rst         = 1'b0;
                    return;
                end
            end
            for (int w = 0; w < v.beats; w++) begin
                @(negedge clk);
                ln_out_vld  = (w == 0) ? 8'h0F : 8'hFF;
                ln_out_last = (w == v.beats - 1);
                #1;
                if (w == 0) begin
                    chk($sformatf("wait_rd_en r%0d", r), 32'(src_rd_en), 32'd0);
                    chk($sformatf("final_mask_in r%0d", r), 32'(ln_in_vld), 32'(v.mask));
                    chk($sformatf("final_mask_param r%0d", r), 32'(ln_param_vld), 32'(v.mask));
                end else begin
                    chk($sformatf("lane_idle r%0d w%0d", r, w), 32'(ln_in_vld), 32'd0);
                end
                ea = v.dst + 12'(r * v.beats + w);
                chk($sformatf("dst_wr_en r%0d w%0d", r, w), 32'(dst_wr_en), 32'd1);
                chk($sformatf("dst_wr_addr r%0d w%0d", r, w), 32'(dst_wr_addr), 32'(ea));
                chk($sformatf("early_done r%0d w%0d", r, w), 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        ln_out_vld  = 8'h00;
        ln_out_last = 1'b0;
        cmd_vld     = 1'b0;
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_rd_en", 32'(src_rd_en), 32'd0);
        @(negedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vr;
        vec_t vn;
        //            rows   dn      isp    osp    src       dst       beats mask   hold  inj
        tbl[0] = '{8'd1, 10'd16, 5'h1B, 5'h03, 12'h100, 12'h000, 2, 8'hFF, 1'b0, 1'b0};
        tbl[1] = '{8'd2, 10'd13, 5'h10, 5'h0F, 12'h000, 12'h200, 2, 8'h1F, 1'b0, 1'b0};
        tbl[2] = '{8'd0, 10'd16, 5'h01, 5'h02, 12'h050, 12'h060, 2, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'd3, 10'd0,  5'h01, 5'h02, 12'h050, 12'h060, 0, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'd1, 10'd16, 5'h05, 5'h1F, 12'hFFF, 12'hFFE, 2, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{8'd2, 10'd5,  5'h0A, 5'h15, 12'h010, 12'h020, 1, 8'h1F, 1'b1, 1'b1};
        tbl[6] = '{8'd3, 10'd24, 5'h11, 5'h07, 12'h7F0, 12'h800, 3, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{8'd1, 10'd1,  5'h00, 5'h00, 12'h123, 12'h456, 1, 8'h01, 1'b0, 1'b0};
        vr     = '{8'd2, 10'd16, 5'h02, 5'h04, 12'h040, 12'h080, 2, 8'hFF, 1'b0, 1'b0};
        vn     = '{8'd1, 10'd8,  5'h06, 5'h09, 12'h300, 12'h310, 1, 8'hFF, 1'b0, 1'b0};

        rst               = 1'b1;
        cmd_vld           = 1'b0;
        cmd_row_num       = '0;
        cmd_data_num      = '0;
        cmd_in_scale_pos  = '0;
        cmd_out_scale_pos = '0;
        cmd_src_base      = '0;
        cmd_dst_base      = '0;
        ln_out_vld        = '0;
        ln_out_last       = 1'b0;
        #2;
        chk_rst("por");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i], -1);
            @(negedge clk);
        end

        // Reset during row 1 streaming, then a new command on the very next cycle.
        run_cmd(vr, 1);
        run_cmd(vn, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
